pool_engine: RTL and testbench
==============================

// Module: pool_engine
// PURPOSE
//  Parametrised 2-D pooling engine for the CNN layer pipeline. Once the preceding
//  layer finishes, it scans each channel's feature map in memory using non-overlapping
//  POOLxPOOL windows. It reduces each window by max or floor-average and writes one
//  result per window to that channel's pooled-output memory. Channels run in order
//  0..CH-1 over the shared crd/cwr/csel memory bus.
// PARAMETERS
//  DATA_W      20  pixel / result width, unsigned
//  IMG_W       64  input map width (pixels)
//  IMG_H       64  input map height (pixels)
//  ADDR_W      12  read/write address width; IMG_W*IMG_H <= 2**ADDR_W
//  POOL        2   window side; power of two, >=2
//  CH          2   channel count
//  CSEL_W      3   memory-select width
//  RD_SEL_BASE 1   csel for reading channel c = RD_SEL_BASE+c
//  WR_SEL_BASE 3   csel for writing channel c = WR_SEL_BASE+c
// PORTS
//  clk       in   1       clock, rising edge
//  reset     in   1       asynchronous, active-high
//  start     in   1       begin a full run; sampled only in IDLE
//  mode      in   1       0 = max pooling, 1 = average pooling; latched with start
//  crd       out  1       memory read strobe
//  csel      out  CSEL_W  memory select (0 when neither crd nor cwr)
//  caddr_rd  out  ADDR_W  read address, row-major: y*IMG_W+x
//  cdata_rd  in   DATA_W  read data; valid the cycle AFTER crd/caddr_rd
//  cwr       out  1       memory write strobe
//  caddr_wr  out  ADDR_W  write address: wy*(IMG_W/POOL)+wx
//  cdata_wr  out  DATA_W  write data
//  busy      out  1       high from the cycle after start is accepted until DONE is left
//  done      out  1       one-cycle pulse after the final write
// BEHAVIOUR
//  Reset: state IDLE; crd=cwr=busy=done=0; csel=0; caddr_rd=caddr_wr=0; cdata_wr=0.
//   All counters clear. Reset mid-run aborts immediately; no further reads or writes.
//  FSM: IDLE -> RD -> LAST -> WR -> (RD | DONE) -> IDLE.
//   IDLE: start=1 -> RD; latch mode; clear ch, wy, wx, k. start is ignored in any other state.
//   RD: POOL*POOL cycles with crd=1 and csel=RD_SEL_BASE+ch.
//    caddr_rd=(wy*POOL+ky)*IMG_W+wx*POOL+kx; k=ky*POOL+kx counts 0..POOL^2-1 (kx fastest).
//    After k=POOL^2-1 -> LAST.
//   LAST: one cycle, crd=0; captures the final sample -> WR.
//   WR: one cycle with cwr=1, csel=WR_SEL_BASE+ch, cdata_wr=result, caddr_wr per window.
//    Then advance wx, then wy, then ch.
//    If this was the last window of channel CH-1 -> DONE, else -> RD.
//   DONE: done=1 for one cycle, busy=1 -> IDLE. start in DONE is ignored.
//  Accumulator: loads the sample arriving the cycle after k=0 and folds each later
//   sample; it never carries over between windows.
//   Max: unsigned compare; result = largest sample.
//   Avg: sum width DATA_W+2*log2(POOL), no overflow. Result = sum>>(2*log2(POOL)),
//    truncated (floor).
//  Timing: POOL^2+2 cycles per window. If start is accepted at edge T0, the first crd
//   is in cycle T0+1 and done is high in cycle T0+1+CH*(IMG_W/POOL)*(IMG_H/POOL)*(POOL^2+2).
//   With defaults, done is in cycle T0+12289.
//  Outputs are decoded from registered state and counters only (Moore).
//   Addresses and cdata_wr hold their last value outside RD/WR.
//  Elaboration checks: IMG_W%POOL==0, IMG_H%POOL==0, POOL a power of two,
//   RD/WR select ranges non-overlapping.
// TESTING
//  1 Defaults, max mode, pixel(x,y)=y*64+x in ch0, ch1 = ch0+5000.
//    -> ch0 out[0]=65, out[1023]=4095; ch1 out[0]=5065.
//    -> 2048 writes; done at cycle T0+12289.
//  2 Avg mode, window {1,2,3,5}. -> cdata_wr=2 (11>>2, floor).
//    Window all 20'hFFFFF -> 20'hFFFFF (no sum overflow).
//  3 IMG_W=IMG_H=8, POOL=4, CH=1, max.
//    -> read order 0,1,2,3,8,9,10,11,16.. for window 0.
//    -> 4 writes at addresses 0..3; 18 cycles per window.
//  4 start held high through the whole run and the DONE cycle.
//    -> exactly one run, then a second run starts from the IDLE cycle after DONE.
//    mode toggled mid-run -> results still use the latched mode.
//  5 reset asserted during RD of window 100.
//    -> all outputs at reset values immediately; no cwr afterwards.
//    A new start -> run begins at window 0, ch0.
//  6 Read-latency check: memory model returns data 1 cycle after crd.
//    Inject a distinct maximum at k=POOL^2-1 -> that value is written (LAST capture).

Source files
------------

// File: rtl/pool_engine.sv
// pool_engine: non-overlapping POOLxPOOL max / floor-average pooling over
// CH feature maps, streamed through a shared read/write memory bus.
module pool_engine #(
    parameter int DATA_W      = 20,
    parameter int IMG_W       = 64,
    parameter int IMG_H       = 64,
    parameter int ADDR_W      = 12,
    parameter int POOL        = 2,
    parameter int CH          = 2,
    parameter int CSEL_W      = 3,
    parameter int RD_SEL_BASE = 1,
    parameter int WR_SEL_BASE = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic              crd,
    output logic [CSEL_W-1:0] csel,
    output logic [ADDR_W-1:0] caddr_rd,
    input  logic [DATA_W-1:0] cdata_rd,
    output logic              cwr,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [DATA_W-1:0] cdata_wr,
    output logic              busy,
    output logic              done
);
    localparam int LG    = $clog2(POOL);
    localparam int KW    = 2 * LG;
    localparam int WX_N  = IMG_W / POOL;
    localparam int WY_N  = IMG_H / POOL;
    localparam int WXW   = (WX_N > 1) ? $clog2(WX_N) : 1;
    localparam int WYW   = (WY_N > 1) ? $clog2(WY_N) : 1;
    localparam int CHW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int SUM_W = DATA_W + KW;

    localparam logic [KW-1:0]  K_LAST  = KW'(POOL * POOL - 1);
    localparam logic [WXW-1:0] WX_LAST = WXW'(WX_N - 1);
    localparam logic [WYW-1:0] WY_LAST = WYW'(WY_N - 1);
    localparam logic [CHW-1:0] CH_LAST = CHW'(CH - 1);

    generate
        if ((IMG_W % POOL) != 0 || (IMG_H % POOL) != 0) begin : g_bad_dim
            $error("pool_engine: image size must be a multiple of POOL");
        end
        if (POOL < 2 || (POOL & (POOL - 1)) != 0) begin : g_bad_pool
            $error("pool_engine: POOL must be a power of two >= 2");
        end
        if (!((RD_SEL_BASE + CH <= WR_SEL_BASE) ||
              (WR_SEL_BASE + CH <= RD_SEL_BASE))) begin : g_bad_sel
            $error("pool_engine: read and write select ranges overlap");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_LAST, S_WR, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [WXW-1:0]     wx_q, wx_d;
    logic [WYW-1:0]     wy_q, wy_d;
    logic [CHW-1:0]     ch_q, ch_d;
    logic               mode_q, mode_d;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]  res_q, res_d;

    logic [LG-1:0]      kx, ky;
    logic [SUM_W-1:0]   samp, fold;
    logic               last_k, last_win;

    assign kx       = k_q[LG-1:0];
    assign ky       = k_q[KW-1:LG];
    assign samp     = {{KW{1'b0}}, cdata_rd};
    assign fold     = mode_q ? (acc_q + samp) : ((samp > acc_q) ? samp : acc_q);
    assign last_k   = (k_q == K_LAST);
    assign last_win = (ch_q == CH_LAST) && (wy_q == WY_LAST) && (wx_q == WX_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            wx_q    <= '0;
            wy_q    <= '0;
            ch_q    <= '0;
            mode_q  <= 1'b0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            ch_q    <= ch_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_RD;
            S_RD:   if (last_k) state_d = S_LAST;
            S_LAST: state_d = S_WR;
            S_WR:   state_d = last_win ? S_DONE : S_RD;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read data lags crd by one cycle: load at k=1, fold through LAST.
    always_comb begin
        k_d    = k_q;
        wx_d   = wx_q;
        wy_d   = wy_q;
        ch_d   = ch_q;
        mode_d = mode_q;
        acc_d  = acc_q;
        res_d  = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d    = '0;
                    wx_d   = '0;
                    wy_d   = '0;
                    ch_d   = '0;
                    mode_d = mode;
                end
            end
            S_RD: begin
                if (!last_k) k_d = k_q + KW'(1);
                if (k_q == KW'(1)) acc_d = samp;
                else if (k_q != '0) acc_d = fold;
            end
            S_LAST: begin
                res_d = mode_q ? DATA_W'(fold >> KW) : fold[DATA_W-1:0];
            end
            S_WR: begin
                if (!last_win) begin
                    k_d = '0;
                    if (wx_q == WX_LAST) begin
                        wx_d = '0;
                        if (wy_q == WY_LAST) begin
                            wy_d = '0;
                            ch_d = ch_q + CHW'(1);
                        end else begin
                            wy_d = wy_q + WYW'(1);
                        end
                    end else begin
                        wx_d = wx_q + WXW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Counters freeze after the last window, so addresses hold their value.
    always_comb begin
        crd      = 1'b0;
        cwr      = 1'b0;
        csel     = '0;
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        cdata_wr = res_q;
        caddr_rd = ADDR_W'((int'(wy_q) * POOL + int'(ky)) * IMG_W
                           + int'(wx_q) * POOL + int'(kx));
        caddr_wr = ADDR_W'(int'(wy_q) * WX_N + int'(wx_q));
        unique case (state_q)
            S_RD: begin
                crd  = 1'b1;
                csel = CSEL_W'(RD_SEL_BASE + int'(ch_q));
            end
            S_WR: begin
                cwr  = 1'b1;
                csel = CSEL_W'(WR_SEL_BASE + int'(ch_q));
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_pool_engine.sv
// tb_pool_engine: randomized bench for pool_engine against a window-level
// model; default 64x64x2 instance plus an 8x8, POOL=4, single-channel one.
module tb_pool_engine;
    logic        clk = 1'b0;
    logic        reset, start, mode;
    logic        crd, cwr, busy, done;
    logic [2:0]  csel;
    logic [11:0] caddr_rd, caddr_wr;
    logic [19:0] cdata_rd, cdata_wr;

    logic        s_start, s_mode, s_crd, s_cwr, s_busy, s_done;
    logic [2:0]  s_csel;
    logic [5:0]  s_ard, s_awr;
    logic [19:0] s_rd, s_wd;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int fc   = 0;
    int run2_w0 = 0;

    logic [19:0] mem  [2][4096];
    logic [19:0] smem [64];
    logic [19:0] got  [2][1024];
    int wcnt = 0, dcnt = 0, dcyc = 0;

    int s_wcnt = 0, s_rcnt = 0, s_dcnt = 0;
    logic [5:0]  s_rlog [16];
    logic [5:0]  s_wadr [4];
    logic [19:0] s_wdat [4];
    int          s_wcyc [4];

    pool_engine u_dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .crd(crd), .csel(csel), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .busy(busy), .done(done)
    );

    pool_engine #(
        .DATA_W(20), .IMG_W(8), .IMG_H(8), .ADDR_W(6), .POOL(4), .CH(1),
        .CSEL_W(3), .RD_SEL_BASE(1), .WR_SEL_BASE(3)
    ) u_small (
        .clk(clk), .reset(reset), .start(s_start), .mode(s_mode),
        .crd(s_crd), .csel(s_csel), .caddr_rd(s_ard), .cdata_rd(s_rd),
        .cwr(s_cwr), .caddr_wr(s_awr), .cdata_wr(s_wd),
        .busy(s_busy), .done(s_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memories: data appears the cycle after the read strobe.
    always @(posedge clk)
        if (crd)
            cdata_rd <= (csel == 3'd1) ? mem[0][caddr_rd] :
                        (csel == 3'd2) ? mem[1][caddr_rd] : 20'h0;

    always @(posedge clk)
        if (s_crd) s_rd <= smem[s_ard];

    always @(negedge clk) begin
        if (cwr && (csel == 3'd3 || csel == 3'd4))
            got[(csel == 3'd4) ? 1 : 0][caddr_wr[9:0]] <= cdata_wr;
        if (cwr) wcnt <= wcnt + 1;
        if (done) begin
            dcnt <= dcnt + 1;
            dcyc <= cyc;
        end
    end

    always @(negedge clk) begin
        if (s_crd && s_rcnt < 16) s_rlog[s_rcnt[3:0]] <= s_ard;
        if (s_crd) s_rcnt <= s_rcnt + 1;
        if (s_cwr && s_wcnt < 4) begin
            s_wadr[s_wcnt[1:0]] <= s_awr;
            s_wdat[s_wcnt[1:0]] <= s_wd;
            s_wcyc[s_wcnt[1:0]] <= cyc;
        end
        if (s_cwr) s_wcnt <= s_wcnt + 1;
        if (s_done) s_dcnt <= s_dcnt + 1;
    end

    function automatic logic [19:0] ref_win(int c, int wy, int wx, logic m);
        longint      sum = 0;
        logic [19:0] mx  = '0;
        logic [19:0] v;
        for (int ky = 0; ky < 2; ky++)
            for (int kx = 0; kx < 2; kx++) begin
                v = mem[c][(wy * 2 + ky) * 64 + wx * 2 + kx];
                sum += longint'(v);
                if (v > mx) mx = v;
            end
        return m ? 20'(sum / 4) : mx;
    endfunction

    function automatic logic [19:0] ref_small(int w);
        logic [19:0] mx = '0;
        logic [19:0] v;
        for (int ky = 0; ky < 4; ky++)
            for (int kx = 0; kx < 4; kx++) begin
                v = smem[((w / 2) * 4 + ky) * 8 + (w % 2) * 4 + kx];
                if (v > mx) mx = v;
            end
        return mx;
    endfunction

    task automatic start_run(input logic m, input logic hold);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        fc = cyc;
        nvec++;
        if (crd !== 1'b1 || caddr_rd !== 12'd0 || csel !== 3'd1 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL first_read: crd=%b addr=%0d csel=%0d busy=%b, expected 1/0/1/1",
                     crd, caddr_rd, csel, busy);
        end
    endtask

    task automatic wait_done(input int n);
        int i = 0;
        while (dcnt < n && i < 14000) begin
            @(negedge clk);
            #1;
            i++;
        end
        nvec++;
        if (dcnt < n) begin
            nerr++;
            $display("FAIL done_timeout: done pulses %0d, expected %0d", dcnt, n);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        s_start = 1'b0; s_mode = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        nvec++;
        if ({crd, cwr, busy, done} !== 4'b0) begin
            nerr++;
            $display("FAIL reset_strobes: crd/cwr/busy/done=%b, expected 0000",
                     {crd, cwr, busy, done});
        end
        nvec++;
        if (csel !== 3'd0 || caddr_rd !== 12'd0 || caddr_wr !== 12'd0) begin
            nerr++;
            $display("FAIL reset_addr: csel=%0d rd=%0d wr=%0d, expected 0/0/0",
                     csel, caddr_rd, caddr_wr);
        end
        nvec++;
        if (cdata_wr !== 20'd0 || s_busy !== 1'b0) begin
            nerr++;
            $display("FAIL reset_data: cdata_wr=%0d s_busy=%b, expected 0/0", cdata_wr, s_busy);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_max_pattern;
        int w0, d0;
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 64; x++) begin
                mem[0][y * 64 + x] = 20'(y * 64 + x);
                mem[1][y * 64 + x] = 20'(y * 64 + x + 5000);
            end
        w0 = wcnt;
        d0 = dcnt;
        start_run(1'b0, 1'b0);
        wait_done(d0 + 1);
        nvec++;
        if (dcyc !== fc + 12288) begin
            nerr++;
            $display("FAIL done_cycle: done %0d cycles after first read, expected 12288", dcyc - fc);
        end
        nvec++;
        if (wcnt - w0 !== 2048) begin
            nerr++;
            $display("FAIL max_writes: %0d writes, expected 2048", wcnt - w0);
        end
        nvec++;
        if (got[0][0] !== 20'd65 || got[0][1023] !== 20'd4095 || got[1][0] !== 20'd5065) begin
            nerr++;
            $display("FAIL max_corners: %0d %0d %0d, expected 65 4095 5065",
                     got[0][0], got[0][1023], got[1][0]);
        end
        for (int c = 0; c < 2; c++)
            for (int w = 0; w < 1024; w++) begin
                nvec++;
                if (got[c][w] !== ref_win(c, w / 32, w % 32, 1'b0)) begin
                    nerr++;
                    $display("FAIL max_win ch%0d w%0d: got %0d, expected %0d",
                             c, w, got[c][w], ref_win(c, w / 32, w % 32, 1'b0));
                end
            end
    endtask

    task automatic test_avg_random;
        int w0, d0;
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 4096; i++) mem[c][i] = 20'($urandom);
        mem[0][0]  = 20'd1;
        mem[0][1]  = 20'd2;
        mem[0][64] = 20'd3;
        mem[0][65] = 20'd5;
        mem[0][2]  = 20'hFFFFF;
        mem[0][3]  = 20'hFFFFF;
        mem[0][66] = 20'hFFFFF;
        mem[0][67] = 20'hFFFFF;
        w0 = wcnt;
        d0 = dcnt;
        start_run(1'b1, 1'b0);
        wait_done(d0 + 1);
        nvec++;
        if (got[0][0] !== 20'd2) begin
            nerr++;
            $display("FAIL avg_floor: got %0d, expected 2", got[0][0]);
        end
        nvec++;
        if (got[0][1] !== 20'hFFFFF) begin
            nerr++;
            $display("FAIL avg_no_ovf: got %h, expected fffff", got[0][1]);
        end
        nvec++;
        if (wcnt - w0 !== 2048) begin
            nerr++;
            $display("FAIL avg_writes: %0d writes, expected 2048", wcnt - w0);
        end
        for (int c = 0; c < 2; c++)
            for (int w = 0; w < 1024; w++) begin
                nvec++;
                if (got[c][w] !== ref_win(c, w / 32, w % 32, 1'b1)) begin
                    nerr++;
                    $display("FAIL avg_win ch%0d w%0d: got %0d, expected %0d",
                             c, w, got[c][w], ref_win(c, w / 32, w % 32, 1'b1));
                end
            end
    endtask

    task automatic test_start_held;
        int w0, d0;
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 4096; i++) mem[c][i] = 20'($urandom);
        w0 = wcnt;
        d0 = dcnt;
        start_run(1'b0, 1'b1);
        repeat (3000) @(negedge clk);
        mode = 1'b1;
        wait_done(d0 + 1);
        nvec++;
        if (done !== 1'b1 || wcnt - w0 !== 2048 || dcnt !== d0 + 1) begin
            nerr++;
            $display("FAIL held_one_run: done=%b writes=%0d pulses=%0d, expected 1/2048/1",
                     done, wcnt - w0, dcnt - d0);
        end
        for (int c = 0; c < 2; c++)
            for (int w = 0; w < 1024; w++) begin
                nvec++;
                if (got[c][w] !== ref_win(c, w / 32, w % 32, 1'b0)) begin
                    nerr++;
                    $display("FAIL held_latched_mode ch%0d w%0d: got %0d, expected %0d",
                             c, w, got[c][w], ref_win(c, w / 32, w % 32, 1'b0));
                end
            end
        @(posedge clk);
        #1;
        nvec++;
        if (busy !== 1'b0 || crd !== 1'b0 || done !== 1'b0) begin
            nerr++;
            $display("FAIL held_idle: busy=%b crd=%b done=%b, expected 0/0/0", busy, crd, done);
        end
        run2_w0 = wcnt;
        @(posedge clk);
        #1;
        nvec++;
        if (crd !== 1'b1 || busy !== 1'b1 || caddr_rd !== 12'd0) begin
            nerr++;
            $display("FAIL held_rerun: crd=%b busy=%b addr=%0d, expected 1/1/0",
                     crd, busy, caddr_rd);
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid;
        int i = 0;
        int w1;
        while (wcnt - run2_w0 < 100 && i < 2000) begin
            @(negedge clk);
            #1;
            i++;
        end
        @(posedge clk);
        #1;
        nvec++;
        if (crd !== 1'b1 || caddr_rd !== 12'd392 || csel !== 3'd1) begin
            nerr++;
            $display("FAIL win100_read: crd=%b addr=%0d csel=%0d, expected 1/392/1",
                     crd, caddr_rd, csel);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        nvec++;
        if ({crd, cwr, busy, done} !== 4'b0 || csel !== 3'd0 || caddr_rd !== 12'd0
            || caddr_wr !== 12'd0 || cdata_wr !== 20'd0) begin
            nerr++;
            $display("FAIL abort_outputs: strobes=%b csel=%0d rd=%0d wr=%0d data=%0d, expected all 0",
                     {crd, cwr, busy, done}, csel, caddr_rd, caddr_wr, cdata_wr);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        w1 = wcnt;
        repeat (40) @(negedge clk);
        #1;
        nvec++;
        if (wcnt !== w1 || busy !== 1'b0 || crd !== 1'b0) begin
            nerr++;
            $display("FAIL abort_quiet: writes=%0d busy=%b crd=%b, expected 0/0/0",
                     wcnt - w1, busy, crd);
        end
        start_run(1'b0, 1'b0);
        i = 0;
        while (cwr !== 1'b1 && i < 20) begin
            @(negedge clk);
            #1;
            i++;
        end
        nvec++;
        if (cwr !== 1'b1 || caddr_wr !== 12'd0 || csel !== 3'd3 || cyc !== fc + 5
            || cdata_wr !== ref_win(0, 0, 0, 1'b0)) begin
            nerr++;
            $display("FAIL restart_first_write: cwr=%b addr=%0d csel=%0d at +%0d data=%0d, expected 1/0/3/+5/%0d",
                     cwr, caddr_wr, csel, cyc - fc, cdata_wr, ref_win(0, 0, 0, 1'b0));
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_small_last_capture;
        int i = 0;
        int sfc;
        for (int a = 0; a < 64; a++) smem[a] = 20'($urandom_range(0, 999));
        smem[3 * 8 + 7] = 20'd1000;
        @(negedge clk);
        s_start = 1'b1;
        s_mode  = 1'b0;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        sfc = cyc;
        while (s_dcnt < 1 && i < 200) begin
            @(negedge clk);
            #1;
            i++;
        end
        nvec++;
        if (s_dcnt !== 1 || s_rcnt !== 64 || s_wcnt !== 4) begin
            nerr++;
            $display("FAIL small_counts: done=%0d reads=%0d writes=%0d, expected 1/64/4",
                     s_dcnt, s_rcnt, s_wcnt);
        end
        for (int k = 0; k < 16; k++) begin
            nvec++;
            if (s_rlog[k] !== 6'((k / 4) * 8 + k % 4)) begin
                nerr++;
                $display("FAIL small_read_order k%0d: got %0d, expected %0d",
                         k, s_rlog[k], (k / 4) * 8 + k % 4);
            end
        end
        for (int w = 0; w < 4; w++) begin
            nvec++;
            if (s_wadr[w] !== 6'(w) || s_wdat[w] !== ref_small(w)
                || s_wcyc[w] !== sfc + 17 + 18 * w) begin
                nerr++;
                $display("FAIL small_write w%0d: addr=%0d data=%0d at +%0d, expected %0d/%0d/+%0d",
                         w, s_wadr[w], s_wdat[w], s_wcyc[w] - sfc, w, ref_small(w), 17 + 18 * w);
            end
        end
        nvec++;
        if (s_wdat[1] !== 20'd1000) begin
            nerr++;
            $display("FAIL last_capture: got %0d, expected 1000", s_wdat[1]);
        end
    endtask

    initial begin
        test_reset();
        test_small_last_capture();
        test_max_pattern();
        test_avg_random();
        test_start_held();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
